// File: rtl/comparador_serial_di.sv
// Bit-serial LSB-to-MSB magnitude comparator with valid/ready handshakes on input and result.
// Define COMPARADOR_FIRMADO_EN to compare the operands as two's complement values.
module comparador_serial_di #(
  parameter int K = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ent_valido,
  output logic         ent_listo,
  input  logic [K-1:0] A,
  input  logic [K-1:0] B,
  output logic         sal_valido,
  input  logic         sal_listo,
  output logic         mayor,
  output logic         igual,
  output logic         menor,
  output logic         ocupado
);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] IDX_ULT = IW'(K - 1);

  typedef enum logic [1:0] {ESPERA, COMPARA, RESULTADO} estado_t;
  typedef enum logic [1:0] {IGUALES, A_MAYOR, A_MENOR} rel_t;

  estado_t       estado_q, estado_d;
  rel_t          rel_q, rel_d, rel_paso;
  logic [K-1:0]  ra_q, ra_d, rb_q, rb_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          sal_valido_q, sal_valido_d;
  logic          mayor_q, mayor_d, igual_q, igual_d, menor_q, menor_d;
  logic          bit_a, bit_b, ultimo, invierte;

  // Per-bit cell: a differing bit overwrites the relation, so the highest difference wins.
  always_comb begin
    bit_a  = ra_q[idx_q];
    bit_b  = rb_q[idx_q];
    ultimo = (idx_q == IDX_ULT);
`ifdef COMPARADOR_FIRMADO_EN
    invierte = ultimo;
`else
    invierte = 1'b0;
`endif
    rel_paso = rel_q;
    if (bit_a != bit_b) begin
      rel_paso = (bit_a ^ invierte) ? A_MAYOR : A_MENOR;
    end
  end

  always_comb begin
    estado_d     = estado_q;
    rel_d        = rel_q;
    ra_d         = ra_q;
    rb_d         = rb_q;
    idx_d        = idx_q;
    sal_valido_d = sal_valido_q;
    mayor_d      = mayor_q;
    igual_d      = igual_q;
    menor_d      = menor_q;
    case (estado_q)
      ESPERA: begin
        if (ent_valido) begin
          ra_d     = A;
          rb_d     = B;
          idx_d    = '0;
          rel_d    = IGUALES;
          estado_d = COMPARA;
        end
      end
      COMPARA: begin
        rel_d = rel_paso;
        if (ultimo) begin
          mayor_d      = (rel_paso == A_MAYOR);
          igual_d      = (rel_paso == IGUALES);
          menor_d      = (rel_paso == A_MENOR);
          sal_valido_d = 1'b1;
          estado_d     = RESULTADO;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      RESULTADO: begin
        if (sal_listo) begin
          sal_valido_d = 1'b0;
          mayor_d      = 1'b0;
          igual_d      = 1'b0;
          menor_d      = 1'b0;
          estado_d     = ESPERA;
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q     <= ESPERA;
      rel_q        <= IGUALES;
      ra_q         <= '0;
      rb_q         <= '0;
      idx_q        <= '0;
      sal_valido_q <= 1'b0;
      mayor_q      <= 1'b0;
      igual_q      <= 1'b0;
      menor_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      rel_q        <= rel_d;
      ra_q         <= ra_d;
      rb_q         <= rb_d;
      idx_q        <= idx_d;
      sal_valido_q <= sal_valido_d;
      mayor_q      <= mayor_d;
      igual_q      <= igual_d;
      menor_q      <= menor_d;
    end
  end

  assign ent_listo  = (estado_q == ESPERA);
  assign ocupado    = (estado_q == COMPARA);
  assign sal_valido = sal_valido_q;
  assign mayor      = mayor_q;
  assign igual      = igual_q;
  assign menor      = menor_q;
endmodule

// File: tb/tb_comparador_serial_di.sv
// Randomized self-checking bench for comparador_serial_di against an arithmetic reference.
// Honours COMPARADOR_FIRMADO_EN when the same define is given to the bench.
module tb_comparador_serial_di;
  localparam int K = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ent_valido = 1'b0;
  logic         ent_listo;
  logic [K-1:0] A = '0;
  logic [K-1:0] B = '0;
  logic         sal_valido;
  logic         sal_listo = 1'b0;
  logic         mayor, igual, menor, ocupado;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  comparador_serial_di #(.K(K)) dut (
    .clk(clk), .rst_n(rst_n), .ent_valido(ent_valido), .ent_listo(ent_listo),
    .A(A), .B(B), .sal_valido(sal_valido), .sal_listo(sal_listo),
    .mayor(mayor), .igual(igual), .menor(menor), .ocupado(ocupado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference result as {mayor, igual, menor}, straight from the numeric relation.
  function automatic logic [2:0] modelo(input logic [K-1:0] a, input logic [K-1:0] b);
`ifdef COMPARADOR_FIRMADO_EN
    if ($signed(a) > $signed(b)) return 3'b100;
    if ($signed(a) < $signed(b)) return 3'b001;
`else
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
`endif
    return 3'b010;
  endfunction

  // Presents a pair and returns once it has been accepted (or the bound expired).
  task automatic ofrecer(input logic [K-1:0] a, input logic [K-1:0] b, input bit soltar,
                         output int tacc, output bit ok);
    logic listo;
    A = a;
    B = b;
    ent_valido = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      listo = ent_listo;
      @(posedge clk);
      #1;
      if (listo) ok = 1'b1;
    end
    tacc = cyc;
    if (soltar) ent_valido = 1'b0;
  endtask

  task automatic esperar(output int lat);
    lat = 0;
    while (sal_valido !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({ent_listo, sal_valido, ocupado} !== 3'b100)
      $display("[TB] FAIL reset_hs: got %b want 100", {ent_listo, sal_valido, ocupado});
    else passed++;
    checks++;
    if ({mayor, igual, menor} !== 3'b000)
      $display("[TB] FAIL reset_res: got %b want 000", {mayor, igual, menor});
    else passed++;
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_dirigido;
    logic [K-1:0] va[3] = '{8'h5A, 8'h00, 8'h81};
    logic [K-1:0] vb[3] = '{8'h5A, 8'h01, 8'h7F};
    int tacc, lat;
    bit ok;
    sal_listo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ofrecer(va[i], vb[i], 1'b1, tacc, ok);
      checks++;
      if (!ok) $display("[TB] FAIL dir_accept[%0d]: got timeout want accept", i); else passed++;
      checks++;
      if (ocupado !== 1'b1) $display("[TB] FAIL dir_ocupado[%0d]: got %b want 1", i, ocupado); else passed++;
      esperar(lat);
      checks++;
      if (lat != K) $display("[TB] FAIL dir_lat[%0d]: got %0d want %0d", i, lat, K); else passed++;
      checks++;
      if ({mayor, igual, menor} !== modelo(va[i], vb[i]))
        $display("[TB] FAIL dir_res[%0d]: got %b want %b", i, {mayor, igual, menor}, modelo(va[i], vb[i]));
      else passed++;
      @(posedge clk);
      #1;
      checks++;
      if ({ent_listo, sal_valido, mayor, igual, menor} !== 5'b10000)
        $display("[TB] FAIL dir_vuelta[%0d]: got %b want 10000", i,
                 {ent_listo, sal_valido, mayor, igual, menor});
      else passed++;
    end
    sal_listo = 1'b0;
  endtask

  task automatic test_aleatorio;
    logic [K-1:0] a, b;
    logic [2:0] esp;
    int tacc, lat, espera;
    bit ok;
    for (int i = 0; i < 16; i++) begin
      a = K'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ K'(1 << $urandom_range(0, K - 1));
        default: b = K'($urandom);
      endcase
      esp = modelo(a, b);
      espera = $urandom_range(0, 3);
      sal_listo = 1'b0;
      ofrecer(a, b, 1'b1, tacc, ok);
      A = K'($urandom);
      B = K'($urandom);
      esperar(lat);
      checks++;
      if (!ok || lat != K) $display("[TB] FAIL rnd_lat[%0d]: got %0d want %0d", i, lat, K); else passed++;
      checks++;
      if ({mayor, igual, menor} !== esp)
        $display("[TB] FAIL rnd_res[%0d] a=%h b=%h: got %b want %b", i, a, b, {mayor, igual, menor}, esp);
      else passed++;
      for (int c = 0; c < espera; c++) begin
        @(posedge clk);
        #1;
        checks++;
        if ({sal_valido, mayor, igual, menor} !== {1'b1, esp})
          $display("[TB] FAIL rnd_hold[%0d]: got %b want %b", i, {sal_valido, mayor, igual, menor}, {1'b1, esp});
        else passed++;
      end
      sal_listo = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({ent_listo, sal_valido, mayor, igual, menor} !== 5'b10000)
        $display("[TB] FAIL rnd_vuelta[%0d]: got %b want 10000", i, {ent_listo, sal_valido, mayor, igual, menor});
      else passed++;
    end
    sal_listo = 1'b0;
  endtask

  task automatic test_contrapresion;
    logic [2:0] esp;
    int tacc, lat;
    bit ok;
    sal_listo = 1'b0;
    esp = modelo(8'h81, 8'h7F);
    ofrecer(8'h81, 8'h7F, 1'b1, tacc, ok);
    esperar(lat);
    checks++;
    if (!ok || lat != K) $display("[TB] FAIL bp_lat: got %0d want %0d", lat, K); else passed++;
    ent_valido = 1'b1;
    A = 8'h11;
    B = 8'h22;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({sal_valido, mayor, igual, menor, ent_listo, ocupado} !== {1'b1, esp, 2'b00})
        $display("[TB] FAIL bp_hold[%0d]: got %b want %b", c,
                 {sal_valido, mayor, igual, menor, ent_listo, ocupado}, {1'b1, esp, 2'b00});
      else passed++;
    end
    ent_valido = 1'b0;
    sal_listo = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({ent_listo, sal_valido, mayor, igual, menor} !== 5'b10000)
      $display("[TB] FAIL bp_vuelta: got %b want 10000", {ent_listo, sal_valido, mayor, igual, menor});
    else passed++;
    sal_listo = 1'b0;
  endtask

  task automatic test_reset_medio;
    int tacc, lat;
    bit ok;
    sal_listo = 1'b1;
    ofrecer(8'hF0, 8'h0F, 1'b1, tacc, ok);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (ocupado !== 1'b1) $display("[TB] FAIL rst_pre: got %b want 1", ocupado); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ent_listo, sal_valido, ocupado, mayor, igual, menor} !== 6'b100000)
      $display("[TB] FAIL rst_medio: got %b want 100000", {ent_listo, sal_valido, ocupado, mayor, igual, menor});
    else passed++;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    ofrecer(8'h03, 8'h03, 1'b1, tacc, ok);
    esperar(lat);
    checks++;
    if (!ok || lat != K) $display("[TB] FAIL rst_lat: got %0d want %0d", lat, K); else passed++;
    checks++;
    if ({mayor, igual, menor} !== 3'b010)
      $display("[TB] FAIL rst_res: got %b want 010", {mayor, igual, menor});
    else passed++;
    @(posedge clk);
    #1;
    sal_listo = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [K-1:0] pa[3], pb[3];
    int tacc, tprev, lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      pa[i] = K'($urandom);
      pb[i] = (i == 1) ? pa[i] : K'($urandom);
    end
    sal_listo = 1'b1;
    tprev = 0;
    for (int i = 0; i < 3; i++) begin
      ofrecer(pa[i], pb[i], 1'b0, tacc, ok);
      checks++;
      if (!ok) $display("[TB] FAIL b2b_accept[%0d]: got timeout want accept", i); else passed++;
      if (i > 0) begin
        checks++;
        if (tacc - tprev != K + 2)
          $display("[TB] FAIL b2b_intervalo[%0d]: got %0d want %0d", i, tacc - tprev, K + 2);
        else passed++;
      end
      tprev = tacc;
      esperar(lat);
      checks++;
      if (lat != K) $display("[TB] FAIL b2b_lat[%0d]: got %0d want %0d", i, lat, K); else passed++;
      checks++;
      if ({mayor, igual, menor} !== modelo(pa[i], pb[i]))
        $display("[TB] FAIL b2b_res[%0d]: got %b want %b", i, {mayor, igual, menor}, modelo(pa[i], pb[i]));
      else passed++;
    end
    ent_valido = 1'b0;
    @(posedge clk);
    #1;
    sal_listo = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dirigido();
    test_aleatorio();
    test_contrapresion();
    test_reset_medio();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
